inert_intf_fusion: RTL and testbench



---
 rtl/seg_pkg.sv | 17 +
 rtl/inert_intf_fusion_if.sv | 20 ++
 rtl/inert_cal.sv | 38 +++
 rtl/inert_intf_fusion.sv | 106 ++++++++++
 tb/tb_inert_intf_fusion.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared types and defaults for the balance-controller front end.
package seg_pkg;

  typedef enum logic {
    CAL = 1'b0,
    RUN = 1'b1
  } inert_state_t;

  // Converts offset-compensated AZ into pitch units (prod >>> 13).
  localparam logic signed [9:0] ACC_SCALE = 10'sd327;

  localparam logic [15:0]  AZ_OFFSET_DEF      = 16'h00A0;
  localparam logic [15:0]  PTCH_RT_OFFSET_DEF = 16'h0050;
  localparam int unsigned  FUSION_GAIN_DEF    = 1024;
  localparam int unsigned  CAL_LOG2_DEF       = 8;

endpackage

// File: rtl/inert_intf_fusion_if.sv
// Sample-in / fused-pitch-out bundle between the IMU reader and the PID stage.
interface inert_intf_fusion_if;
  logic               vld;
  logic signed [15:0] ptch_rt_raw;
  logic signed [15:0] AZ;
  logic signed [15:0] ptch;
  logic signed [15:0] ptch_rt;
  logic               ptch_vld;
  logic               cal_done;

  modport master (
    output vld, ptch_rt_raw, AZ,
    input  ptch, ptch_rt, ptch_vld, cal_done
  );

  modport slave (
    input  vld, ptch_rt_raw, AZ,
    output ptch, ptch_rt, ptch_vld, cal_done
  );
endinterface

// File: rtl/inert_cal.sv
// Power-up gyro offset learner: averages 2^CAL_LOG2 raw samples into the offset register.
module inert_cal
  import seg_pkg::*;
#(
  parameter logic [15:0] OFFSET_INIT = PTCH_RT_OFFSET_DEF,
  parameter int unsigned CAL_LOG2    = CAL_LOG2_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_en,
  input  logic signed [15:0] ptch_rt_raw,
  output logic        [15:0] offset,
  output logic               cal_last_c
);

  localparam int unsigned ACC_W = 16 + CAL_LOG2;

  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_sum_c;
  logic [CAL_LOG2-1:0] cnt_q;

  assign acc_sum_c  = acc_q + {{CAL_LOG2{ptch_rt_raw[15]}}, ptch_rt_raw};
  assign cal_last_c = sample_en && (cnt_q == '1);

  // The final sample is folded in before the mean is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      offset <= OFFSET_INIT;
    end else if (sample_en) begin
      acc_q <= acc_sum_c;
      cnt_q <= cnt_q + CAL_LOG2'(1);
      if (cal_last_c) offset <= acc_sum_c[ACC_W-1:CAL_LOG2];
    end
  end

endmodule

// File: rtl/inert_intf_fusion.sv
// Gyro offset compensation and gyro/accel complementary fusion of pitch.
// Optional power-up offset calibration under INERT_AUTOCAL_EN.
module inert_intf_fusion
  import seg_pkg::*;
#(
  parameter logic [15:0] AZ_OFFSET      = AZ_OFFSET_DEF,
  parameter logic [15:0] PTCH_RT_OFFSET = PTCH_RT_OFFSET_DEF,
`ifdef INERT_AUTOCAL_EN
  parameter int unsigned CAL_LOG2       = CAL_LOG2_DEF,
`endif
  parameter int unsigned FUSION_GAIN    = FUSION_GAIN_DEF
) (
  input  logic clk,
  input  logic rst,
  inert_intf_fusion_if.slave bus
);

`ifdef INERT_AUTOCAL_EN
  localparam inert_state_t RESET_STATE = CAL;
`else
  localparam inert_state_t RESET_STATE = RUN;
`endif

  localparam logic signed [26:0] GAIN = 27'(FUSION_GAIN);

  inert_state_t       state_q, state_nxt;
  logic        [15:0] offset;
  logic               cal_last_c;
  logic               sample_c;

  logic signed [26:0] ptch_int_q;
  logic signed [15:0] ptch_rt_q;
  logic               ptch_vld_q;
  logic               cal_done_q;

  logic signed [15:0] ptch_c;
  logic signed [15:0] comp_c;
  logic signed [15:0] az_comp_c;
  logic signed [25:0] prod_c;
  logic signed [15:0] ptch_acc_c;
  logic signed [26:0] fusion_c;
  logic signed [26:0] ptch_int_nxt_c;

`ifdef INERT_AUTOCAL_EN
  inert_cal #(
    .OFFSET_INIT (PTCH_RT_OFFSET),
    .CAL_LOG2    (CAL_LOG2)
  ) u_cal (
    .clk         (clk),
    .rst         (rst),
    .sample_en   (bus.vld && (state_q == CAL)),
    .ptch_rt_raw (bus.ptch_rt_raw),
    .offset      (offset),
    .cal_last_c  (cal_last_c)
  );
`else
  assign offset     = PTCH_RT_OFFSET;
  assign cal_last_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= RESET_STATE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    sample_c  = 1'b0;
    case (state_q)
      CAL:     if (cal_last_c) state_nxt = RUN;
      RUN:     sample_c = bus.vld;
      default: state_nxt = RESET_STATE;
    endcase
  end

  // Fusion datapath: integrate the compensated rate, nudge toward the accel pitch.
  assign ptch_c         = ptch_int_q[26:11];
  assign comp_c         = bus.ptch_rt_raw - offset;
  assign az_comp_c      = bus.AZ - AZ_OFFSET;
  assign prod_c         = 26'(az_comp_c) * 26'(ACC_SCALE);
  assign ptch_acc_c     = 16'(prod_c >>> 13);
  assign fusion_c       = (ptch_acc_c > ptch_c) ? GAIN : -GAIN;
  assign ptch_int_nxt_c = ptch_int_q - 27'(comp_c) + fusion_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptch_int_q <= '0;
      ptch_rt_q  <= '0;
      ptch_vld_q <= 1'b0;
      cal_done_q <= 1'b0;
    end else begin
      ptch_vld_q <= sample_c;
      cal_done_q <= (state_nxt == RUN);
      if (sample_c) begin
        ptch_int_q <= ptch_int_nxt_c;
        ptch_rt_q  <= comp_c;
      end
    end
  end

  assign bus.ptch     = ptch_c;
  assign bus.ptch_rt  = ptch_rt_q;
  assign bus.ptch_vld = ptch_vld_q;
  assign bus.cal_done = cal_done_q;

endmodule

// File: tb/tb_inert_intf_fusion.sv
// Randomized self-checking bench for inert_intf_fusion against an arithmetic reference model.
// Runs the calibration scenarios as well when INERT_AUTOCAL_EN is defined.
module tb_inert_intf_fusion;

`ifdef INERT_AUTOCAL_EN
  localparam bit AUTOCAL = 1'b1;
`else
  localparam bit AUTOCAL = 1'b0;
`endif
  localparam int CAL_N = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_err = 0;
  int   n_chk = 0;

  inert_intf_fusion_if bus ();

  inert_intf_fusion dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state, kept as plain integers.
  longint m_int, m_rt, m_off, m_sum;
  int     m_cnt;
  bit     m_vld, m_done, m_cal;

  function automatic longint sx(input longint x, input int w);
    longint m;
    longint r;
    m = longint'(1) << w;
    r = x & (m - 1);
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [15:0] raw,
                            input logic [15:0] az);
    longint comp, azc, acc, cur, fus;
    if (r) begin
      m_int = 0; m_rt = 0; m_vld = 0; m_done = 0;
      m_off = 'h50; m_cnt = 0; m_sum = 0; m_cal = AUTOCAL;
      return;
    end
    m_vld = 0;
    if (v && m_cal) begin
      m_sum += sx(longint'(raw), 16);
      m_cnt++;
      if (m_cnt == CAL_N) begin
        m_off = (m_sum >>> 8) & 'hFFFF;
        m_cal = 0;
      end
    end else if (v) begin
      comp  = sx(longint'(raw) - m_off, 16);
      azc   = sx(longint'(az) - 'hA0, 16);
      acc   = (azc * 327) >>> 13;
      cur   = m_int >>> 11;
      fus   = (acc > cur) ? 1024 : -1024;
      m_int = sx(m_int - comp + fus, 27);
      m_rt  = comp;
      m_vld = 1;
    end
    if (!m_cal) m_done = 1;
  endtask

  task automatic tick(input logic r, input logic v, input logic [15:0] raw, input logic [15:0] az);
    rst             = r;
    bus.vld         = v;
    bus.ptch_rt_raw = raw;
    bus.AZ          = az;
    model_step(r, v, raw, az);
    @(negedge clk);
    chk("ptch_vld", 32'(bus.ptch_vld), 32'(m_vld));
    chk("ptch",     32'($unsigned(bus.ptch)), 32'((m_int >>> 11) & 'hFFFF));
    chk("ptch_rt",  32'($unsigned(bus.ptch_rt)), 32'(m_rt & 'hFFFF));
    chk("cal_done", 32'(bus.cal_done), 32'(m_done));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // Feeds n calibration samples; random gaps, optionally random raw values.
  task automatic cal_feed(input int n, input logic [15:0] raw, input bit rnd);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b1, rnd ? 16'($urandom_range(0, 16'h0FFF)) - 16'h0800 + raw : raw, 16'h00A0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
  endtask

  task automatic reset_dut();
    tick(1'b1, 1'b0, 16'h0, 16'h0);
    tick(1'b1, 1'b0, 16'h0, 16'h0);
    tick(1'b0, 1'b0, 16'h0, 16'h0);
    if (AUTOCAL) cal_feed(CAL_N, 16'h0050, 1'b0);
  endtask

  task automatic sample(input logic [15:0] raw, input logic [15:0] az, input int gap);
    tick(1'b0, 1'b1, raw, az);
    idle(gap);
  endtask

  initial begin
    bus.vld = 1'b0; bus.ptch_rt_raw = '0; bus.AZ = '0;
    @(negedge clk);

    // Reset state and release.
    tick(1'b1, 1'b0, 16'h0, 16'h0);
    chk("rst_cal_done", 32'(bus.cal_done), 32'h0);
    chk("rst_ptch", 32'($unsigned(bus.ptch)), 32'h0);
    reset_dut();
    chk("cal_done_up", 32'(bus.cal_done), 32'h1);

    // Zero input: pitch dithers around zero.
    for (int i = 0; i < 10; i++) begin
      sample(16'h0050, 16'h00A0, $urandom_range(0, 2));
      chk("dither", 32'((bus.ptch == 16'hFFFF) || (bus.ptch == 16'h0000)), 32'h1);
    end
    chk("zero_rt", 32'($unsigned(bus.ptch_rt)), 32'h0);

    // Constant negative rate.
    reset_dut();
    for (int i = 0; i < 8; i++) sample(16'hF050, 16'h00A0, $urandom_range(0, 1));
    chk("neg_rate_ptch", 32'($unsigned(bus.ptch)), 32'd12);
    chk("neg_rate_rt", 32'($unsigned(bus.ptch_rt)), 32'hF000);

    // Accel pulls pitch up to 10.
    reset_dut();
    for (int i = 0; i < 20; i++) sample(16'h0050, 16'h01A0, 0);
    chk("accel_ptch20", 32'($unsigned(bus.ptch)), 32'd10);
    for (int i = 0; i < 6; i++) sample(16'h0050, 16'h01A0, 0);

    // Back-to-back samples, random data.
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 16'($urandom), 16'($urandom));
    idle(2);

    // Random traffic with a mid-run reset.
    for (int i = 0; i < 300; i++) begin
      if (i == 150) reset_dut();
      tick(1'b0, ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'h0050 + 16'($urandom_range(0, 63)) - 16'd32,
           ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'h00A0 + 16'($urandom_range(0, 1023)) - 16'd512);
    end

    if (AUTOCAL) begin
      // Learn a 0x60 offset; no ptch_vld during calibration.
      tick(1'b1, 1'b0, 16'h0, 16'h0);
      tick(1'b0, 1'b0, 16'h0, 16'h0);
      cal_feed(CAL_N - 1, 16'h0060, 1'b0);
      chk("cal_pending", 32'(bus.cal_done), 32'h0);
      cal_feed(1, 16'h0060, 1'b0);
      chk("cal_done_rise", 32'(bus.cal_done), 32'h1);
      sample(16'h0060, 16'h00A0, 1);
      chk("cal_rt_zero", 32'($unsigned(bus.ptch_rt)), 32'h0);

      // Reset at sample 100 restarts the full count.
      tick(1'b1, 1'b0, 16'h0, 16'h0);
      tick(1'b0, 1'b0, 16'h0, 16'h0);
      cal_feed(100, 16'h0060, 1'b0);
      tick(1'b1, 1'b1, 16'h0060, 16'h00A0);
      chk("mid_rst_done", 32'(bus.cal_done), 32'h0);
      chk("mid_rst_ptch_rt", 32'($unsigned(bus.ptch_rt)), 32'h0);
      cal_feed(CAL_N - 1, 16'h0040, 1'b0);
      chk("restart_pending", 32'(bus.cal_done), 32'h0);
      cal_feed(1, 16'h0040, 1'b0);
      chk("restart_done", 32'(bus.cal_done), 32'h1);

      // Random calibration samples: truncated mean, then random run.
      tick(1'b1, 1'b0, 16'h0, 16'h0);
      tick(1'b0, 1'b0, 16'h0, 16'h0);
      cal_feed(CAL_N, 16'hFFF0, 1'b1);
      for (int i = 0; i < 40; i++)
        tick(1'b0, ($urandom_range(0, 1) != 0), 16'($urandom), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
